// File: rtl/dma_io_device_if.sv
// dma_io_device_if: 8237A channel handshake, bus data and client byte ports of a DMA I/O device
interface dma_io_device_if;
  logic       enable, dir, demand_mode;
  logic       dreq, dack_n, ior_n, iow_n, eop_n, eop_drive;
  logic [7:0] data_in, data_out;
  logic       data_out_en;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       tc_done, err_flag;
  modport slave (
    input  enable, dir, demand_mode, dack_n, ior_n, iow_n, eop_n, data_in,
           tx_valid, tx_data, tx_last, rx_ready,
    output dreq, eop_drive, data_out, data_out_en, tx_ready, rx_valid, rx_data,
           tc_done, err_flag
  );
  modport master (
    output enable, dir, demand_mode, dack_n, ior_n, iow_n, eop_n, data_in,
           tx_valid, tx_data, tx_last, rx_ready,
    input  dreq, eop_drive, data_out, data_out_en, tx_ready, rx_valid, rx_data,
           tc_done, err_flag
  );
endinterface

// File: rtl/dma_io_device.sv
// dma_io_device: device side of an 8237A DMA channel with a byte FIFO to a valid/ready client.
// DMA_DEV_EOP_EN: store txLast as a 9th FIFO bit, drive EOP and terminate on the tagged byte.
module dma_io_device #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  dma_io_device_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef DMA_DEV_EOP_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, GRANT, STROBE, TERM} state_t;
  state_t state;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic dir_q, a_q, eop_seen, dreq_q, tc_q, err_q;
  logic empty, full, ready, ready_idle, ready_after, s, a, rel, commit, push, pop, head_last, term;
  logic [W-1:0] head, wdata;
  always_comb begin
    empty = count == '0;
    full = count == FULL;
    ready = dir_q ? ~full : ~empty;
    ready_idle = bus.dir ? ~full : ~empty;
    ready_after = dir_q ? count < FULL - CW'(1) : count > CW'(1);
    s = dir_q ? ~bus.iow_n : ~bus.ior_n;
    a = s & ~bus.dack_n;
    rel = a_q & ~a;
    commit = state == STROBE && rel;
    head = mem[rp];
    push = dir_q ? commit & ~full : bus.tx_valid & bus.tx_ready;
    pop = dir_q ? bus.rx_valid & bus.rx_ready : commit & ~empty;
`ifdef DMA_DEV_EOP_EN
    wdata = {bus.tx_last & ~dir_q, dir_q ? bus.data_in : bus.tx_data};
    head_last = ~dir_q & ~empty & head[8];
`else
    wdata = dir_q ? bus.data_in : bus.tx_data;
    head_last = 1'b0;
`endif
    term = eop_seen | ~bus.eop_n | head_last;
  end
  assign bus.tx_ready = ~dir_q & ~full & bus.enable;
  assign bus.rx_valid = dir_q & ~empty;
  assign bus.rx_data = bus.rx_valid ? head[7:0] : '0;
  assign bus.data_out = (~dir_q & ~empty) ? head[7:0] : '0;
  assign bus.data_out_en = state == STROBE && ~dir_q && ~bus.ior_n && ~bus.dack_n;
  assign bus.eop_drive = bus.data_out_en & head_last;
  assign bus.dreq = dreq_q;
  assign bus.tc_done = tc_q;
  assign bus.err_flag = err_q;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {dir_q, a_q, eop_seen, dreq_q, tc_q, err_q} <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      a_q <= a;
      if (!bus.enable) begin
        state <= IDLE;
        {eop_seen, dreq_q, tc_q, err_q} <= '0;
        dir_q <= bus.dir;
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        wp <= wp + AW'(push);
        rp <= rp + AW'(pop);
        count <= count + CW'(push) - CW'(pop);
        // bus errors are flagged on any acknowledged strobe, not only inside a granted cycle
        if (rel && (dir_q ? full : empty)) err_q <= 1'b1;
        case (state)
          IDLE: begin
            dreq_q <= 1'b0;
            dir_q <= bus.dir;
            if (ready_idle) state <= REQ;
          end
          REQ: begin
            dreq_q <= 1'b1;
            if (!bus.dack_n) state <= GRANT;
          end
          GRANT: begin
            dreq_q <= bus.demand_mode & ready;
            if (a) begin
              state <= STROBE;
              eop_seen <= ~bus.eop_n;
            end else if (bus.dack_n) state <= IDLE;
          end
          STROBE: begin
            dreq_q <= bus.demand_mode & ready & ~(rel & term);
            eop_seen <= eop_seen | ~bus.eop_n;
            if (rel) begin
              if (term) begin
                state <= TERM;
                tc_q <= 1'b1;
              end else state <= (!bus.dack_n && bus.demand_mode && ready_after) ? GRANT : IDLE;
            end
          end
          TERM: dreq_q <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dma_io_device.sv
// tb_dma_io_device: directed bench for dma_io_device acting as the DMA controller and the client.
module tb_dma_io_device;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  dma_io_device_if bus();
  dma_io_device #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_dreq"}, 32'(bus.dreq), 0);
    check({tag, "_eopd"}, 32'(bus.eop_drive), 0);
    check({tag, "_oe"}, 32'(bus.data_out_en), 0);
    check({tag, "_dout"}, 32'(bus.data_out), 0);
    check({tag, "_txrdy"}, 32'(bus.tx_ready), 0);
    check({tag, "_rxv"}, 32'(bus.rx_valid), 0);
    check({tag, "_rxd"}, 32'(bus.rx_data), 0);
    check({tag, "_tc"}, 32'(bus.tc_done), 0);
    check({tag, "_err"}, 32'(bus.err_flag), 0);
    check({tag, "_count"}, 32'(dut.count), 0);
  endtask
  task automatic flush(input logic d, input logic dm);
    bus.enable = 1'b0;
    bus.dir = d;
    bus.demand_mode = dm;
    tick(2);
    bus.enable = 1'b1;
    tick();
  endtask
  task automatic push(input logic [7:0] b, input logic l);
    bus.tx_valid = 1'b1;
    bus.tx_data = b;
    bus.tx_last = l;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_last = 1'b0;
  endtask
  task automatic wait_dreq(input string tag);
    int n = 0;
    while (!bus.dreq && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.dreq), 1);
  endtask
  task automatic ior_cycle(input string tag, input logic [7:0] exp, input logic eop, input logic exp_eopd);
    bus.dack_n = 1'b0;
    tick();
    bus.ior_n = 1'b0;
    bus.eop_n = ~eop;
    tick();
    check({tag, "_oe"}, 32'(bus.data_out_en), 1);
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp));
    check({tag, "_eopd"}, 32'(bus.eop_drive), 32'(exp_eopd));
    check({tag, "_dreq"}, 32'(bus.dreq), 0);
    bus.ior_n = 1'b1;
    tick();
    bus.eop_n = 1'b1;
    bus.dack_n = 1'b1;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.dir = 1'b0;
    bus.demand_mode = 1'b0;
    bus.dack_n = 1'b1;
    bus.ior_n = 1'b1;
    bus.iow_n = 1'b1;
    bus.eop_n = 1'b1;
    bus.data_in = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    bus.tx_last = 1'b0;
    bus.rx_ready = 1'b0;
    tick(2);
    check_reset("rst");
    rst = 1'b0;
    // single-mode reads of A1,B2,C3
    flush(1'b0, 1'b0);
    push(8'hA1, 1'b0);
    push(8'hB2, 1'b0);
    check("t1_dreq_early", 32'(bus.dreq), 0);
    push(8'hC3, 1'b0);
    check("t1_dreq_lat", 32'(bus.dreq), 1);
    ior_cycle("t1_b0", 8'hA1, 1'b0, 1'b0);
    wait_dreq("t1_rereq1");
    ior_cycle("t1_b1", 8'hB2, 1'b0, 1'b0);
    wait_dreq("t1_rereq2");
    ior_cycle("t1_b2", 8'hC3, 1'b0, 1'b0);
    tick(4);
    check("t1_dreq_end", 32'(bus.dreq), 0);
    check("t1_count_end", 32'(dut.count), 0);
    check("t1_err", 32'(bus.err_flag), 0);
    // demand-mode writes 00..07 fill the FIFO, then an overrun
    flush(1'b1, 1'b1);
    wait_dreq("t2_req");
    bus.dack_n = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.data_in = 8'(i);
      bus.iow_n = 1'b0;
      tick();
      bus.iow_n = 1'b1;
      tick();
      if (i < 7) check($sformatf("t2_hold%0d", i), 32'(bus.dreq), 1);
    end
    tick();
    check("t2_drop", 32'(bus.dreq), 0);
    check("t2_count", 32'(dut.count), 8);
    check("t2_err_pre", 32'(bus.err_flag), 0);
    bus.data_in = 8'h99;
    bus.iow_n = 1'b0;
    tick();
    bus.iow_n = 1'b1;
    tick();
    check("t2_overrun", 32'(bus.err_flag), 1);
    check("t2_count_keep", 32'(dut.count), 8);
    bus.dack_n = 1'b1;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_rx%0d", i), 32'(bus.rx_data), i);
      tick();
    end
    bus.rx_ready = 1'b0;
    check("t2_rx_empty", 32'(bus.rx_valid), 0);
    // EOP from the controller during the second of four reads
    flush(1'b0, 1'b0);
    push(8'h10, 1'b0);
    push(8'h11, 1'b0);
    push(8'h12, 1'b0);
    push(8'h13, 1'b0);
    wait_dreq("t3_req");
    ior_cycle("t3_b0", 8'h10, 1'b0, 1'b0);
    wait_dreq("t3_rereq");
    ior_cycle("t3_b1", 8'h11, 1'b1, 1'b0);
    check("t3_tc", 32'(bus.tc_done), 1);
    check("t3_state", 32'(dut.state), 4);
    check("t3_count", 32'(dut.count), 2);
    tick(3);
    check("t3_dreq", 32'(bus.dreq), 0);
    bus.enable = 1'b0;
    tick();
    check("t3_tc_clr", 32'(bus.tc_done), 0);
    check("t3_flushed", 32'(dut.count), 0);
    // txLast on the second of three bytes
    flush(1'b0, 1'b0);
    push(8'h20, 1'b0);
    push(8'h21, 1'b1);
    push(8'h22, 1'b0);
    wait_dreq("t4_req");
    ior_cycle("t4_b0", 8'h20, 1'b0, 1'b0);
    wait_dreq("t4_rereq");
`ifdef DMA_DEV_EOP_EN
    ior_cycle("t4_b1", 8'h21, 1'b0, 1'b1);
    check("t4_tc", 32'(bus.tc_done), 1);
    check("t4_count", 32'(dut.count), 1);
    tick(3);
    check("t4_dreq", 32'(bus.dreq), 0);
`else
    ior_cycle("t4_b1", 8'h21, 1'b0, 1'b0);
    check("t4_tc", 32'(bus.tc_done), 0);
    wait_dreq("t4_rereq2");
`endif
    // reset in the middle of a read strobe
    flush(1'b0, 1'b0);
    push(8'h33, 1'b0);
    wait_dreq("t5_req");
    bus.dack_n = 1'b0;
    tick();
    bus.ior_n = 1'b0;
    tick();
    check("t5_oe_pre", 32'(bus.data_out_en), 1);
    #2 rst = 1'b1;
    #1 check("t5_oe_async", 32'(bus.data_out_en), 0);
    bus.enable = 1'b0;
    tick();
    check_reset("t5");
    rst = 1'b0;
    bus.ior_n = 1'b1;
    bus.dack_n = 1'b1;
    tick();
    // unacknowledged read is ignored; acknowledged read of an empty FIFO underruns
    flush(1'b0, 1'b0);
    bus.ior_n = 1'b0;
    tick(2);
    bus.ior_n = 1'b1;
    tick();
    check("t6_noack_err", 32'(bus.err_flag), 0);
    bus.dack_n = 1'b0;
    bus.ior_n = 1'b0;
    tick();
    check("t6_dout", 32'(bus.data_out), 0);
    bus.ior_n = 1'b1;
    tick();
    check("t6_underrun", 32'(bus.err_flag), 1);
    bus.dack_n = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
